mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. It sequences fetch/decode/execute/mem/writeback
//  and drives datapath selects: imm_sel to imm_gen, ALU operand/op selects, PC update, RF/IR

---
 rtl/mc_ctrl_fsm.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm - multi-cycle control FSM for an RV32I core.
//
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath
// selects for the instruction currently held in the IR. Fetch and data memory
// accesses are bounded by WAIT_MAX cycles. An illegal opcode or a memory
// timeout parks the FSM in TRAP until reset.
//
// Ports
//   clk, rst       : core clock, synchronous active-high reset
//   instr          : IR contents (only the opcode field steers this FSM)
//   imem_rdata_v   : fetch data valid this cycle
//   dmem_ready     : data access completes this cycle
//   branch_taken   : branch comparator result, used in EXEC
//   imem_req/ir_we : fetch request / latch fetched word into IR
//   dmem_req/we    : data request / store
//   imm_sel        : 000 I, 001 S, 010 B, 011 U, 100 J, 111 none
//   alu_src_a/b,op : ALU operand and operation selects
//   pc_we/pc_sel   : PC update strobe / next-PC source
//   rf_we/wb_sel   : register write strobe / write-back source
//   halt,trap_cause: sticky trap flag and its cause
//   instret        : retired instruction counter (wraps)
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             imem_rdata_v,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [2:0]       imm_sel,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             halt,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter only needs to reach WAIT_MAX-1; keep at least one bit.
    localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    state_t             r_state;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_instret;
    logic               r_halt;
    logic [1:0]         r_trap_cause;

    state_t             w_next_state;
    logic               w_retire;
    logic [1:0]         w_cause;
    logic [6:0]         w_opcode;
    logic               w_legal;
    logic [2:0]         w_imm;
    logic [1:0]         w_src_a;
    logic               w_src_b;
    logic [1:0]         w_op;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_is_load      = (w_opcode == OP_LOAD);
    assign w_is_store     = (w_opcode == OP_STORE);
    // Operand fields are consumed by the datapath, not by this FSM.
    assign w_unused_instr = &{1'b0, instr[31:7]};

    // Opcode-derived immediate type and ALU selects for the current instruction
    always_comb begin
        w_legal = 1'b1;
        w_imm   = 3'b111;
        w_src_a = 2'b00;
        w_src_b = 1'b0;
        w_op    = 2'b00;
        case (w_opcode)
            OP_R:      w_op = 2'b10;
            OP_I:      begin w_imm = 3'b000; w_src_b = 1'b1; w_op = 2'b10; end
            OP_LOAD:   begin w_imm = 3'b000; w_src_b = 1'b1; end
            OP_STORE:  begin w_imm = 3'b001; w_src_b = 1'b1; end
            OP_BRANCH: begin w_imm = 3'b010; w_op = 2'b01; end
            OP_LUI:    begin w_imm = 3'b011; w_src_a = 2'b10; w_src_b = 1'b1; end
            OP_AUIPC:  begin w_imm = 3'b011; w_src_a = 2'b01; w_src_b = 1'b1; end
            OP_JAL:    w_imm = 3'b100;
            OP_JALR:   begin w_imm = 3'b000; w_src_b = 1'b1; end
            default:   w_legal = 1'b0;
        endcase
    end

    // Next-state, retire and trap-cause selection
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_cause      = 2'b00;
        case (r_state)
            S_FETCH: begin
                // Ready on the last allowed cycle still wins over the timeout.
                if (imem_rdata_v) begin
                    w_next_state = S_DECODE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = S_TRAP;
                    w_cause      = 2'b10;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next_state = S_EXEC;
                end else begin
                    w_next_state = S_TRAP;
                    w_cause      = 2'b01;
                end
            end
            S_EXEC: begin
                case (w_opcode)
                    OP_R, OP_I, OP_LUI, OP_AUIPC: w_next_state = S_WB;
                    OP_LOAD, OP_STORE:            w_next_state = S_MEM;
                    OP_BRANCH, OP_JAL, OP_JALR: begin
                        w_next_state = S_FETCH;
                        w_retire     = 1'b1;
                    end
                    default: begin
                        w_next_state = S_TRAP;
                        w_cause      = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (w_is_store) begin
                        w_next_state = S_FETCH;
                        w_retire     = 1'b1;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = S_TRAP;
                    w_cause      = 2'b11;
                end else begin
                    w_next_state = S_MEM;
                end
            end
            S_WB: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_TRAP:  w_next_state = S_TRAP;
            default: begin
                w_next_state = S_TRAP;
                w_cause      = 2'b01;
            end
        endcase
    end

    // State, wait counter, retire counter and sticky trap registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_wait_cnt   <= '0;
            r_instret    <= '0;
            r_halt       <= 1'b0;
            r_trap_cause <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_next_state != r_state) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if ((w_next_state == S_TRAP) && (r_state != S_TRAP)) begin
                r_halt       <= 1'b1;
                r_trap_cause <= w_cause;
            end
        end
    end

    // Datapath strobes and selects decoded from the current state and opcode
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        imm_sel   = 3'b111;
        alu_src_a = 2'b00;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        if (rst) begin
            imm_sel = 3'b111;
        end else begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_rdata_v;
                end
                S_DECODE: imm_sel = w_imm;
                S_EXEC: begin
                    imm_sel   = w_imm;
                    alu_src_a = w_src_a;
                    alu_src_b = w_src_b;
                    alu_op    = w_op;
                    case (w_opcode)
                        OP_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_sel = branch_taken ? 2'b01 : 2'b00;
                        end
                        OP_JAL: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'b10;
                            pc_we  = 1'b1;
                            pc_sel = 2'b01;
                        end
                        OP_JALR: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'b10;
                            pc_we  = 1'b1;
                            pc_sel = 2'b10;
                        end
                        default: pc_we = 1'b0;
                    endcase
                end
                S_MEM: begin
                    imm_sel   = w_imm;
                    alu_src_a = w_src_a;
                    alu_src_b = w_src_b;
                    alu_op    = w_op;
                    dmem_req  = 1'b1;
                    dmem_we   = w_is_store;
                    // A completing store retires here, so it also advances PC.
                    pc_we     = dmem_ready & w_is_store;
                end
                S_WB: begin
                    imm_sel   = w_imm;
                    alu_src_a = w_src_a;
                    alu_src_b = w_src_b;
                    alu_op    = w_op;
                    rf_we     = 1'b1;
                    wb_sel    = w_is_load ? 2'b01 : 2'b00;
                    pc_we     = 1'b1;
                end
                S_TRAP:  imm_sel = 3'b111;
                default: imm_sel = 3'b111;
            endcase
        end
    end

    assign halt       = r_halt;
    assign trap_cause = r_trap_cause;
    assign instret    = r_instret;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm - self-checking bench for mc_ctrl_fsm.
// Each instruction is expanded into a list of phases (fetch waits, decode,
// execute, memory waits, write-back) from the instruction's class, and the
// expected strobes of every cycle are looked up from per-class tables.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    localparam int WAIT_MAX = 16;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
    localparam int C_LUI = 5, C_AUIPC = 6, C_JAL = 7, C_JALR = 8;
    localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        imem_rdata_v;
    logic        dmem_ready;
    logic        branch_taken;
    logic        imem_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        halt;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_instret;

    logic [6:0] opc_tab  [0:8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                   7'b1100111};
    logic [2:0] imm_tab  [0:8] = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b010,
                                   3'b011, 3'b011, 3'b100, 3'b000};
    logic [1:0] srca_tab [0:8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                   2'b10, 2'b01, 2'b00, 2'b00};
    logic       srcb_tab [0:8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       chks_tab [0:8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] op_tab   [0:8] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01,
                                   2'b00, 2'b00, 2'b00, 2'b00};
    logic       chko_tab [0:8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    mc_ctrl_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .imem_rdata_v (imem_rdata_v),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .halt         (halt),
        .trap_cause   (trap_cause),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom();
        return r[0];
    endfunction

    function automatic logic [20:0] observed();
        return {imem_req, ir_we, dmem_req, dmem_we, imm_sel, alu_src_a, alu_src_b,
                alu_op, pc_we, pc_sel, rf_we, wb_sel, halt, trap_cause};
    endfunction

    function automatic logic [31:0] make_word(input int cls);
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], opc_tab[cls]};
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        instr        = $urandom();
        imem_rdata_v = rbit();
        dmem_ready   = rbit();
        branch_taken = rbit();
        @(posedge clk); #1;
        rst          = 1'b0;
        imem_rdata_v = 1'b0;
        dmem_ready   = 1'b0;
        exp_instret  = 32'd0;
    endtask

    // Run one instruction: fw fetch waits, mw memory waits, tk 0/1 fixed or 2 random.
    task automatic run_instr(input int cls, input logic [31:0] word, input int fw,
                             input int mw, input int tk, input string name);
        int   ph_q[$];
        bit   rdy_q[$];
        logic [20:0] e, m, act;
        logic e_ireq, e_irwe, e_dreq, e_dwe, e_b, e_pcwe, e_rfwe;
        logic [2:0] e_imm;
        logic [1:0] e_a, e_op, e_pcs, e_wbs;
        logic m_s, m_o;
        for (int i = 0; i < fw; i++) begin ph_q.push_back(PH_F); rdy_q.push_back(1'b0); end
        ph_q.push_back(PH_F); rdy_q.push_back(1'b1);
        ph_q.push_back(PH_D); rdy_q.push_back(1'b0);
        ph_q.push_back(PH_E); rdy_q.push_back(1'b0);
        if (cls == C_LD || cls == C_ST) begin
            for (int i = 0; i < mw; i++) begin ph_q.push_back(PH_M); rdy_q.push_back(1'b0); end
            ph_q.push_back(PH_M); rdy_q.push_back(1'b1);
        end
        if (cls == C_R || cls == C_I || cls == C_LUI || cls == C_AUIPC || cls == C_LD) begin
            ph_q.push_back(PH_W); rdy_q.push_back(1'b0);
        end
        for (int k = 0; k < ph_q.size(); k++) begin
            instr        = (ph_q[k] == PH_F) ? $urandom() : word;
            imem_rdata_v = (ph_q[k] == PH_F) ? rdy_q[k] : rbit();
            dmem_ready   = (ph_q[k] == PH_M) ? rdy_q[k] : rbit();
            branch_taken = (tk == 2) ? rbit() : tk[0];
            e_ireq = 1'b0; e_irwe = 1'b0; e_dreq = 1'b0; e_dwe = 1'b0;
            e_imm = 3'b111; e_a = 2'b00; e_b = 1'b0; e_op = 2'b00;
            e_pcwe = 1'b0; e_pcs = 2'b00; e_rfwe = 1'b0; e_wbs = 2'b00;
            m_s = 1'b0; m_o = 1'b0;
            if (ph_q[k] == PH_F) begin
                e_ireq = 1'b1;
                e_irwe = rdy_q[k];
            end else begin
                e_imm = imm_tab[cls];
            end
            if (ph_q[k] == PH_E || ph_q[k] == PH_M) begin
                e_a = srca_tab[cls]; e_b = srcb_tab[cls]; e_op = op_tab[cls];
                m_s = chks_tab[cls]; m_o = chko_tab[cls];
            end
            if (ph_q[k] == PH_E && cls == C_BR) begin
                e_pcwe = 1'b1;
                e_pcs  = branch_taken ? 2'b01 : 2'b00;
            end
            if (ph_q[k] == PH_E && (cls == C_JAL || cls == C_JALR)) begin
                e_rfwe = 1'b1; e_wbs = 2'b10; e_pcwe = 1'b1;
                e_pcs  = (cls == C_JAL) ? 2'b01 : 2'b10;
            end
            if (ph_q[k] == PH_M) begin
                e_dreq = 1'b1;
                e_dwe  = (cls == C_ST);
                e_pcwe = rdy_q[k] && (cls == C_ST);
            end
            if (ph_q[k] == PH_W) begin
                e_rfwe = 1'b1; e_pcwe = 1'b1;
                e_wbs  = (cls == C_LD) ? 2'b01 : 2'b00;
            end
            e = {e_ireq, e_irwe, e_dreq, e_dwe, e_imm, e_a, e_b, e_op,
                 e_pcwe, e_pcs, e_rfwe, e_wbs, 1'b0, 2'b00};
            m = {4'hF, 3'b111, {2{m_s}}, m_s, {2{m_o}}, 1'b1, {2{e_pcwe}},
                 1'b1, {2{e_rfwe}}, 1'b1, 2'b11};
            @(negedge clk);
            act = observed();
            n_checks++;
            if ((act & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL %s cycle %0d phase %0d: got %b expected %b (care %b)",
                         name, k, ph_q[k], act, e, m);
            end
            @(posedge clk); #1;
        end
        exp_instret = exp_instret + 32'd1;
        n_checks++;
        if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL %s instret: got %0d expected %0d", name, instret, exp_instret);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr = $urandom(); imem_rdata_v = rbit(); dmem_ready = rbit(); branch_taken = rbit();
            @(negedge clk);
            n_checks++;
            if ({imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we} !== 6'b0 || imm_sel !== 3'b111) begin
                n_fail++;
                $display("FAIL reset_strobes: got %b imm %b expected 000000 imm 111",
                         {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we}, imm_sel);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; imem_rdata_v = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || halt !== 1'b0 || trap_cause !== 2'b00 || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got req %b halt %b cause %b instret %0d expected 1 0 00 0",
                     imem_req, halt, trap_cause, instret);
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_addi();
        do_reset();
        run_instr(C_I, 32'h00500093, 0, 0, 2, "addi");
    endtask

    task automatic test_load_delay();
        run_instr(C_LD, 32'h0000a083, 0, 3, 2, "lw_delay3");
    endtask

    task automatic test_branch();
        run_instr(C_BR, 32'h00000063, 0, 0, 1, "beq_taken");
        run_instr(C_BR, 32'h00000063, 0, 0, 0, "beq_not_taken");
    endtask

    task automatic test_jal();
        run_instr(C_JAL, 32'h0080006f, 0, 0, 2, "jal");
        run_instr(C_JALR, 32'h000080e7, 1, 0, 2, "jalr");
    endtask

    task automatic test_random();
        int cls;
        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, 8);
            run_instr(cls, make_word(cls), $urandom_range(0, 5), $urandom_range(0, 5), 2, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int cls = 0; cls < 9; cls++) begin
            run_instr(cls, make_word(cls), 0, 0, 2, "back_to_back");
        end
    endtask

    task automatic test_illegal();
        instr = $urandom(); imem_rdata_v = 1'b1;
        @(posedge clk); #1;
        instr = 32'h0000007f; imem_rdata_v = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imm_sel !== 3'b111 || {imem_req, dmem_req, pc_we, rf_we} !== 4'b0 || halt !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_decode: got imm %b strobes %b halt %b expected 111 0000 0",
                     imm_sel, {imem_req, dmem_req, pc_we, rf_we}, halt);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            instr = $urandom(); imem_rdata_v = rbit(); dmem_ready = rbit(); branch_taken = rbit();
            @(negedge clk);
            n_checks++;
            if (halt !== 1'b1 || trap_cause !== 2'b01 || instret !== exp_instret ||
                {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we} !== 6'b0) begin
                n_fail++;
                $display("FAIL illegal_trap: got halt %b cause %b instret %0d strobes %b expected 1 01 %0d 000000",
                         halt, trap_cause, instret, {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we},
                         exp_instret);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; imem_rdata_v = 1'b0;
        @(negedge clk);
        n_checks++;
        if (halt !== 1'b0 || trap_cause !== 2'b00 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_exit_reset: got halt %b cause %b req %b expected 0 00 1",
                     halt, trap_cause, imem_req);
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_imem_timeout();
        do_reset();
        for (int i = 0; i < WAIT_MAX; i++) begin
            dmem_ready = rbit();
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b1 || halt !== 1'b0) begin
                n_fail++;
                $display("FAIL imem_wait cycle %0d: got req %b halt %b expected 1 0", i, imem_req, halt);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (halt !== 1'b1 || trap_cause !== 2'b10 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL imem_timeout: got halt %b cause %b req %b expected 1 10 0",
                     halt, trap_cause, imem_req);
        end
        @(posedge clk); #1;
        do_reset();
        run_instr(C_I, make_word(C_I), WAIT_MAX - 1, 0, 2, "imem_ready_at_limit");
    endtask

    task automatic test_dmem_timeout();
        do_reset();
        instr = $urandom(); imem_rdata_v = 1'b1;
        @(posedge clk); #1;
        instr = make_word(C_LD); imem_rdata_v = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            n_checks++;
            if (dmem_req !== 1'b1 || halt !== 1'b0) begin
                n_fail++;
                $display("FAIL dmem_wait cycle %0d: got req %b halt %b expected 1 0", i, dmem_req, halt);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (halt !== 1'b1 || trap_cause !== 2'b11 || dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL dmem_timeout: got halt %b cause %b req %b expected 1 11 0",
                     halt, trap_cause, dmem_req);
        end
        @(posedge clk); #1;
        do_reset();
        run_instr(C_ST, make_word(C_ST), 0, WAIT_MAX - 1, 2, "dmem_ready_at_limit");
    endtask

    task automatic test_rst_mid();
        do_reset();
        run_instr(C_I, 32'h00500093, 0, 0, 2, "pre_rst_addi");
        instr = $urandom(); imem_rdata_v = 1'b1;
        @(posedge clk); #1;
        instr = make_word(C_ST); imem_rdata_v = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_store_pending: got req %b we %b expected 1 1", dmem_req, dmem_we);
        end
        @(posedge clk); #1;
        rst = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we} !== 6'b0 || imm_sel !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_mid_strobes: got %b imm %b expected 000000 imm 111",
                     {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we}, imm_sel);
        end
        @(posedge clk); #1;
        rst = 1'b0; dmem_ready = 1'b0; imem_rdata_v = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || dmem_req !== 1'b0 || pc_we !== 1'b0 || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_refetch: got req %b dreq %b pc_we %b instret %0d expected 1 0 0 0",
                     imem_req, dmem_req, pc_we, instret);
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        exp_instret  = 32'd0;
        rst          = 1'b1;
        instr        = 32'd0;
        imem_rdata_v = 1'b0;
        dmem_ready   = 1'b0;
        branch_taken = 1'b0;
        test_reset();
        test_addi();
        test_load_delay();
        test_branch();
        test_jal();
        test_back_to_back();
        test_random();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
